// File: rtl/memory_accessor_pkg.sv
// Shared types and decode helpers for the memory-access pipeline stage.
`default_nettype none
package memory_accessor_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

    typedef struct packed {
        logic       lb;
        logic       lh;
        logic       lw;
        logic       lbu;
        logic       lhu;
        logic       sb;
        logic       sh;
        logic       sw;
        logic [4:0] rd;
    } ctrl_info_t;

    function automatic logic is_load(input ctrl_info_t c);
        return c.lb | c.lh | c.lw | c.lbu | c.lhu;
    endfunction

    function automatic logic is_store(input ctrl_info_t c);
        return c.sb | c.sh | c.sw;
    endfunction

    function automatic mem_size_t op_size(input ctrl_info_t c);
        if (c.lw | c.sw)
            return WORD;
        else if (c.lh | c.lhu | c.sh)
            return HALF;
        return BYTE;
    endfunction

    // Byte ops (and non-memory ops, which report BYTE) can never be misaligned.
    function automatic logic is_misaligned(input ctrl_info_t c, input logic [1:0] lo);
        case (op_size(c))
            WORD:    return |lo;
            HALF:    return lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_formatter.sv
// Combinational byte-lane steering: store enables/data replication and load extract/extend.
`default_nettype none
module mem_lane_formatter
    import memory_accessor_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = 32'h0;
        o_load_data = 32'h0;
        w_byte      = i_rdata[8*i_addr_lo +: 8];
        w_half      = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        if (i_is_store) begin
            case (i_size)
                BYTE: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_rs2[7:0]}};
                end
                HALF: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_rs2[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_rs2;
                end
            endcase
        end else if (i_is_load) begin
            o_be = 4'b1111;
            case (i_size)
                BYTE:    o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
                HALF:    o_load_data = {{16{i_signed & w_half[15]}}, w_half};
                default: o_load_data = i_rdata;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_accessor.sv
// Memory pipeline stage: accepts an executed op, runs a req/ack data-memory access when
// needed and presents a writeback record to the next stage.
`default_nettype none
module memory_accessor
    import memory_accessor_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  ctrl_info_t        i_ctr_info,
    input  logic [31:0]       i_exec_result,
    input  logic [31:0]       i_rs2_val,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_wb_en,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_value,
    output logic              o_misalign
);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    ctrl_info_t        r_ctr;
    logic [ADDR_W-1:0] r_word_addr;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_rs2;
    logic              r_misalign;
    logic [31:0]       r_wb_value;

    logic              w_accept;
    logic              w_in_mem;
    logic              w_in_mis;
    logic [31:0]       w_load_data;

    assign w_accept = i_in_valid && o_in_ready;
    assign w_in_mem = is_load(i_ctr_info) || is_store(i_ctr_info);
    assign w_in_mis = w_in_mem && is_misaligned(i_ctr_info, i_exec_result[1:0]);

    // Everything driven toward memory comes from registers, so it is stable for the whole REQ.
    mem_lane_formatter u_fmt (
        .i_size      (op_size(r_ctr)),
        .i_is_load   (is_load(r_ctr)),
        .i_is_store  (is_store(r_ctr)),
        .i_signed    (r_ctr.lb | r_ctr.lh),
        .i_addr_lo   (r_addr_lo),
        .i_rs2       (r_rs2),
        .i_rdata     (i_mem_rdata),
        .o_be        (o_mem_be),
        .o_wdata     (o_mem_wdata),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid)
                    w_state_nxt = (w_in_mem && !w_in_mis) ? REQ : RESP;
            end
            REQ: begin
                if (i_mem_ack)
                    w_state_nxt = RESP;
            end
            RESP: begin
                o_in_ready = i_out_ready;
                if (i_out_ready) begin
                    if (i_in_valid)
                        w_state_nxt = (w_in_mem && !w_in_mis) ? REQ : RESP;
                    else
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ctr       <= '0;
            r_word_addr <= '0;
            r_addr_lo   <= 2'b00;
            r_rs2       <= 32'h0;
            r_misalign  <= 1'b0;
            r_wb_value  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ctr       <= i_ctr_info;
                r_word_addr <= i_exec_result[ADDR_W+1:2];
                r_addr_lo   <= i_exec_result[1:0];
                r_rs2       <= i_rs2_val;
                r_misalign  <= w_in_mis;
                r_wb_value  <= i_exec_result;
            end else if (r_state == REQ && i_mem_ack && is_load(r_ctr)) begin
                r_wb_value  <= w_load_data;
            end
        end
    end

    assign o_mem_req   = (r_state == REQ);
    assign o_mem_we    = (r_state == REQ) && is_store(r_ctr);
    assign o_mem_addr  = r_word_addr;
    assign o_out_valid = (r_state == RESP);
    assign o_misalign  = (r_state == RESP) && r_misalign;
    assign o_wb_en     = (r_state == RESP) && !r_misalign && !is_store(r_ctr) && (r_ctr.rd != 5'd0);
    assign o_wb_rd     = r_ctr.rd;
    assign o_wb_value  = r_wb_value;

endmodule
`default_nettype wire

// File: tb/tb_memory_accessor.sv
// Randomised self-checking bench for memory_accessor against a spec-level reference model.
`default_nettype none
module tb_memory_accessor;
    import memory_accessor_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    ctrl_info_t  i_ctr_info;
    logic [31:0] i_exec_result;
    logic [31:0] i_rs2_val;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_out_valid;
    logic        i_out_ready;
    logic        o_wb_en;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_value;
    logic        o_misalign;

    int vectors;
    int miscompares;

    memory_accessor #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_ctr_info(i_ctr_info),
        .i_exec_result(i_exec_result), .i_rs2_val(i_rs2_val),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .i_mem_ack(i_mem_ack), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_value(o_wb_value), .o_misalign(o_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // op codes: 0 alu, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw
    function automatic ctrl_info_t mk_ctrl(input int op, input logic [4:0] rd);
        ctrl_info_t c;
        c = '0;
        c.rd = rd;
        case (op)
            1: c.lb = 1'b1;
            2: c.lh = 1'b1;
            3: c.lw = 1'b1;
            4: c.lbu = 1'b1;
            5: c.lhu = 1'b1;
            6: c.sb = 1'b1;
            7: c.sh = 1'b1;
            8: c.sw = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic model(input int op, input logic [4:0] rd, input logic [31:0] exec, rs2, rdata,
                         output logic access, output logic we, output logic [15:0] addr,
                         output logic [3:0] be, output logic [31:0] wdata, output logic wb_en,
                         output logic [31:0] wbv, output logic mis);
        int unsigned size, off, b, h;
        logic st, ld;
        ld = (op >= 1 && op <= 5);
        st = (op >= 6);
        size = (op == 3 || op == 8) ? 4 : (op == 2 || op == 5 || op == 7) ? 2 : (op == 0) ? 0 : 1;
        off = exec % 4;
        mis = (size > 0) && ((exec % size) != 0);
        access = (size > 0) && !mis;
        we = st;
        addr = 16'((exec / 4) % 65536);
        be = 4'hF;
        wdata = 32'h0;
        if (op == 6) begin be = 4'(1 << off); wdata = rs2[7:0] * 32'h0101_0101; end
        if (op == 7) begin be = (off >= 2) ? 4'hC : 4'h3; wdata = rs2[15:0] * 32'h0001_0001; end
        if (op == 8) wdata = rs2;
        b = (rdata >> (8 * off)) % 256;
        h = (rdata >> (16 * (off / 2))) % 65536;
        wbv = exec;
        if (access && ld) begin
            case (op)
                1: wbv = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                4: wbv = b;
                2: wbv = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                5: wbv = h;
                default: wbv = rdata;
            endcase
        end
        wb_en = !st && !mis && (rd != 0);
    endtask

    task automatic run_op(input int op, input logic [4:0] rd, input logic [31:0] exec, rs2, rdata,
                          input int ack_dly, output logic saw_req, output int req_cycles,
                          output logic [15:0] addr, output logic [3:0] be, output logic [31:0] wdata,
                          output logic we, output logic stable, output logic wb_en,
                          output logic [4:0] wb_rd, output logic [31:0] wb_value, output logic mis,
                          output int lat, output logic tmo);
        int n;
        saw_req = 0; req_cycles = 0; stable = 1; tmo = 0; lat = 0;
        addr = 0; be = 0; wdata = 0; we = 0; wb_en = 0; wb_rd = 0; wb_value = 0; mis = 0;
        n = 0;
        while (!o_in_ready && n < 50) begin @(posedge clk); #2; n++; end
        if (!o_in_ready) begin tmo = 1; return; end
        i_in_valid = 1'b1;
        i_ctr_info = mk_ctrl(op, rd);
        i_exec_result = exec;
        i_rs2_val = rs2;
        @(posedge clk); #2;
        i_in_valid = 1'b0;
        n = 0;
        while (!o_out_valid && n < 50) begin
            if (o_mem_req) begin
                if (!saw_req) begin
                    saw_req = 1; addr = o_mem_addr; be = o_mem_be; wdata = o_mem_wdata; we = o_mem_we;
                end else if (o_mem_addr !== addr || o_mem_be !== be || o_mem_wdata !== wdata || o_mem_we !== we) begin
                    stable = 0;
                end
                req_cycles++;
                if (req_cycles == ack_dly + 1) begin i_mem_ack = 1'b1; i_mem_rdata = rdata; end
            end
            @(posedge clk); #2;
            i_mem_ack = 1'b0;
            i_mem_rdata = $urandom;
            n++;
        end
        lat = n - req_cycles;
        if (!o_out_valid) begin tmo = 1; return; end
        wb_en = o_wb_en; wb_rd = o_wb_rd; wb_value = o_wb_value; mis = o_misalign;
        i_out_ready = 1'b1;
        @(posedge clk); #2;
        i_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        logic [31:0] flat;
        do_reset();
        vectors++;
        if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b exp 1", o_in_ready); end
        flat = {o_mem_req, o_mem_we, o_out_valid, o_wb_en, o_misalign, o_mem_be, o_wb_rd};
        vectors++;
        if (flat !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h exp 0", flat); end
        vectors++;
        if ({o_mem_addr, o_mem_wdata, o_wb_value} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h exp 0", o_mem_addr, o_mem_wdata, o_wb_value);
        end
    endtask

    task automatic test_alu();
        logic sr, be_ok, we, st, en, mis, tmo; int rc, lat;
        logic [15:0] a; logic [3:0] be; logic [31:0] wd, v; logic [4:0] rd;
        run_op(0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, sr, rc, a, be, wd, we, st, en, rd, v, mis, lat, tmo);
        be_ok = 1'b0;
        vectors++;
        if (tmo || sr || lat != 0) begin miscompares++; $display("FAIL alu_flow: tmo %b req %b lat %0d exp 0 0 0", tmo, sr, lat); end
        vectors++;
        if ({en, rd, v, mis} !== {1'b1, 5'd5, 32'h1234, be_ok}) begin
            miscompares++; $display("FAIL alu_record: got en %b rd %0d val %h mis %b exp 1 5 00001234 0", en, rd, v, mis);
        end
    endtask

    task automatic test_load_byte();
        logic sr, we, st, en, mis, tmo; int rc, lat;
        logic [15:0] a; logic [3:0] be; logic [31:0] wd, v; logic [4:0] rd;
        run_op(1, 5'd7, 32'h103, 32'h0, 32'h80FF_0000, 2, sr, rc, a, be, wd, we, st, en, rd, v, mis, lat, tmo);
        vectors++;
        if (tmo || !sr || rc != 3 || !st) begin miscompares++; $display("FAIL lb_req: tmo %b req %b cycles %0d stable %b exp 0 1 3 1", tmo, sr, rc, st); end
        vectors++;
        if ({a, be, we} !== {16'h40, 4'hF, 1'b0}) begin miscompares++; $display("FAIL lb_bus: got addr %h be %b we %b exp 0040 1111 0", a, be, we); end
        vectors++;
        if ({en, v} !== {1'b1, 32'hFFFF_FF80}) begin miscompares++; $display("FAIL lb_value: got en %b val %h exp 1 ffffff80", en, v); end
    endtask

    task automatic test_store_half();
        logic sr, we, st, en, mis, tmo; int rc, lat;
        logic [15:0] a; logic [3:0] be; logic [31:0] wd, v; logic [4:0] rd;
        run_op(7, 5'd3, 32'h22, 32'hABCD_1234, 32'h0, 1, sr, rc, a, be, wd, we, st, en, rd, v, mis, lat, tmo);
        vectors++;
        if ({tmo, sr, we, be, wd, a} !== {1'b0, 1'b1, 1'b1, 4'b1100, 32'h1234_1234, 16'h8}) begin
            miscompares++; $display("FAIL sh_bus: got req %b we %b be %b wdata %h addr %h exp 1 1 1100 12341234 0008", sr, we, be, wd, a);
        end
        vectors++;
        if (en !== 1'b0) begin miscompares++; $display("FAIL sh_wb_en: got %b exp 0", en); end
    endtask

    task automatic test_misaligned();
        logic sr, we, st, en, mis, tmo; int rc, lat;
        logic [15:0] a; logic [3:0] be; logic [31:0] wd, v; logic [4:0] rd;
        run_op(3, 5'd9, 32'h6, 32'h0, 32'h0, 0, sr, rc, a, be, wd, we, st, en, rd, v, mis, lat, tmo);
        vectors++;
        if ({tmo, sr, lat == 0, mis, en} !== 5'b00110) begin
            miscompares++; $display("FAIL lw_misalign: got tmo %b req %b lat %0d mis %b en %b exp 0 0 0 1 0", tmo, sr, lat, mis, en);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        i_in_valid = 1'b1; i_ctr_info = mk_ctrl(0, 5'd1); i_exec_result = 32'hAAAA_0001;
        @(posedge clk); #2;
        i_ctr_info = mk_ctrl(0, 5'd2); i_exec_result = 32'hBBBB_0002;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_wb_value !== 32'hAAAA_0001 || o_wb_rd !== 5'd1) ok = 1'b0;
            @(posedge clk); #2;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL stall_hold: got ready %b valid %b val %h exp 0 1 aaaa0001", o_in_ready, o_out_valid, o_wb_value); end
        i_out_ready = 1'b1;
        #1;
        vectors++;
        if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b exp 1", o_in_ready); end
        @(posedge clk); #2;
        i_in_valid = 1'b0;
        vectors++;
        if ({o_out_valid, o_wb_rd, o_wb_value} !== {1'b1, 5'd2, 32'hBBBB_0002}) begin
            miscompares++; $display("FAIL b2b_second: got valid %b rd %0d val %h exp 1 2 bbbb0002", o_out_valid, o_wb_rd, o_wb_value);
        end
        @(posedge clk); #2;
        i_out_ready = 1'b0;
        vectors++;
        if (o_out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got valid %b exp 0", o_out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic sr, we, st, en, mis, tmo, seen; int rc, lat;
        logic [15:0] a; logic [3:0] be; logic [31:0] wd, v; logic [4:0] rd;
        i_in_valid = 1'b1; i_ctr_info = mk_ctrl(3, 5'd4); i_exec_result = 32'h40;
        @(posedge clk); #2;
        i_in_valid = 1'b0;
        vectors++;
        if (o_mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_req: got %b exp 1", o_mem_req); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_mem_req, o_out_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_async: got req %b valid %b exp 0 0", o_mem_req, o_out_valid); end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_mem_ack = 1'b1;
            @(posedge clk); #2;
            if (o_out_valid || o_mem_req) seen = 1'b1;
        end
        i_mem_ack = 1'b0;
        vectors++;
        if (seen) begin miscompares++; $display("FAIL rst_discard: got stray valid/req exp none"); end
        run_op(3, 5'd0, 32'h80, 32'h0, 32'h1357_9BDF, 0, sr, rc, a, be, wd, we, st, en, rd, v, mis, lat, tmo);
        vectors++;
        if ({tmo, sr, en, v} !== {1'b0, 1'b1, 1'b0, 32'h1357_9BDF}) begin
            miscompares++; $display("FAIL lw_rd0: got tmo %b req %b en %b val %h exp 0 1 0 13579bdf", tmo, sr, en, v);
        end
    endtask

    task automatic test_random();
        logic sr, we, st, en, mis, tmo; int rc, lat;
        logic [15:0] a; logic [3:0] be; logic [31:0] wd, v; logic [4:0] rd;
        logic e_acc, e_we, e_en, e_mis; logic [15:0] e_a; logic [3:0] e_be; logic [31:0] e_wd, e_v;
        int op, dly; logic [4:0] r; logic [31:0] ex, rs2, rdat;
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 8);
            r = 5'($urandom);
            ex = $urandom;
            rs2 = $urandom;
            rdat = $urandom;
            dly = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                i_mem_ack = 1'b1; i_mem_rdata = $urandom;
                @(posedge clk); #2;
                i_mem_ack = 1'b0;
            end
            model(op, r, ex, rs2, rdat, e_acc, e_we, e_a, e_be, e_wd, e_en, e_v, e_mis);
            run_op(op, r, ex, rs2, rdat, dly, sr, rc, a, be, wd, we, st, en, rd, v, mis, lat, tmo);
            vectors++;
            if (tmo || sr !== e_acc || lat != 0 || !st) begin
                miscompares++; $display("FAIL rnd_flow[%0d] op %0d: tmo %b req %b lat %0d stable %b exp req %b", t, op, tmo, sr, lat, st, e_acc);
            end
            if (e_acc) begin
                vectors++;
                if (a !== e_a || be !== e_be || we !== e_we || rc != dly + 1 || (e_we && wd !== e_wd)) begin
                    miscompares++;
                    $display("FAIL rnd_bus[%0d] op %0d: got a %h be %b we %b wd %h cyc %0d exp %h %b %b %h %0d", t, op, a, be, we, wd, rc, e_a, e_be, e_we, e_wd, dly + 1);
                end
            end
            vectors++;
            if ({en, rd, v, mis} !== {e_en, r, e_v, e_mis}) begin
                miscompares++;
                $display("FAIL rnd_rec[%0d] op %0d ex %h: got en %b rd %0d val %h mis %b exp %b %0d %h %b", t, op, ex, en, rd, v, mis, e_en, r, e_v, e_mis);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        i_in_valid = 1'b0;
        i_ctr_info = '0;
        i_exec_result = 32'h0;
        i_rs2_val = 32'h0;
        i_mem_rdata = 32'h0;
        i_mem_ack = 1'b0;
        i_out_ready = 1'b0;
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
